// File: rtl/data_mem.sv
// Data memory behind the RV32I core: word RAM with little-endian lane steering,
// alignment checking, 1-cycle registered reads and a small MMIO window (cycle counter, LEDs).
module data_mem #(
    parameter int ADDR_W   = 10,
    parameter int MMIO_BIT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        r_en,
    input  logic [31:0] r_addr,
    input  logic [1:0]  r_bmul,
    output logic [31:0] r_data,
    input  logic        w_en,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    input  logic [1:0]  w_bmul,
    input  logic        err_clr,
    output logic        misalign_err,
    output logic [7:0]  leds
);

    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic is_legal(input logic [1:0] lo, input logic [1:0] bmul);
        logic ok;
        case (bmul)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (lo[0] == 1'b0);
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [1:0] bmul);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (bmul)
            2'b00:   res = {24'h000000, sh[7:0]};
            2'b01:   res = {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [1:0] bmul);
        logic [3:0] m;
        case (bmul)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = 4'b0011 << {lo[1], 1'b0};
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] bmul);
        logic [31:0] d;
        case (bmul)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       r_data_q, r_data_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [7:0]        leds_q, leds_d;
    logic              err_q, err_d;
    logic              r_acc_s, w_acc_s, r_ok_s, w_ok_s, r_mmio_s, w_mmio_s, ram_we_s;
    logic [3:0]        w_mask_s;
    logic [31:0]       w_lanes_s, r_word_s, mmio_rd_s;
    logic [ADDR_W-1:0] r_idx_s, w_idx_s;
    logic              unused_s;

    // High RAM address bits alias by design; fold them here so they count as consumed.
    assign unused_s = ^{r_addr, w_addr};

    // Request decode: acceptance, legality, window select and lane steering.
    always_comb begin
        r_acc_s   = clk_enable & r_en;
        w_acc_s   = clk_enable & w_en;
        r_ok_s    = is_legal(r_addr[1:0], r_bmul);
        w_ok_s    = is_legal(w_addr[1:0], w_bmul);
        r_mmio_s  = r_addr[MMIO_BIT];
        w_mmio_s  = w_addr[MMIO_BIT];
        r_idx_s   = r_addr[ADDR_W+1:2];
        w_idx_s   = w_addr[ADDR_W+1:2];
        w_mask_s  = lane_mask(w_addr[1:0], w_bmul);
        w_lanes_s = lane_data(w_data, w_bmul);
        ram_we_s  = w_acc_s & w_ok_s & ~w_mmio_s & ~rst;
    end

    // Source word for a read: MMIO register or the (pre-write) RAM word.
    always_comb begin
        case (r_addr[3:2])
            2'b00:   mmio_rd_s = cnt_q;
            2'b01:   mmio_rd_s = {24'h000000, leds_q};
            default: mmio_rd_s = 32'h00000000;
        endcase
        if (r_mmio_s) begin
            r_word_s = mmio_rd_s;
        end else begin
            r_word_s = mem_q[r_idx_s];
        end
    end

    // Next-state for read data, LEDs, sticky error and the free-running counter.
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (r_acc_s) begin
            if (r_ok_s) begin
                r_data_d = lane_extract(r_word_s, r_addr[1:0], r_bmul);
            end else begin
                r_data_d = 32'h00000000;
            end
        end else begin
            r_data_d = r_data_q;
        end
        // LED register lives in lane 0 of MMIO word 1.
        if (w_acc_s && w_ok_s && w_mmio_s && (w_addr[3:2] == 2'b01) && w_mask_s[0]) begin
            leds_d = w_lanes_s[7:0];
        end else begin
            leds_d = leds_q;
        end
        if ((r_acc_s && !r_ok_s) || (w_acc_s && !w_ok_s)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q <= 32'h00000000;
            cnt_q    <= 32'h00000000;
            leds_q   <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            r_data_q <= r_data_d;
            cnt_q    <= cnt_d;
            leds_q   <= leds_d;
            err_q    <= err_d;
        end
    end

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask_s[i]) begin
                    mem_q[w_idx_s][8*i +: 8] <= w_lanes_s[8*i +: 8];
                end
            end
        end
    end

    assign r_data       = r_data_q;
    assign leds         = leds_q;
    assign misalign_err = err_q;

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Single-port-per-direction data memory sitting directly downstream of the RV32I core's data memory interface.
- Consumes the core's read/write requests: enable, address, data and byte multiplicity (bmul).
- Returns read data with fixed 1-cycle latency, so data is valid by the core's WRITEBACK tick.
- Contains word-organised RAM, little-endian byte-lane steering, alignment checking, and a small MMIO window (free-running cycle counter, LED register).

Parameters:
ADDR_W, 10, RAM word-address width; RAM holds 2**ADDR_W 32-bit words.
MMIO_BIT, 31, address bit that selects the MMIO window (1 = MMIO, 0 = RAM).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
clk_enable  in  1  qualifies request sampling and RAM writes; counter runs regardless
r_en  in  1  read request, sampled on rising clk
r_addr  in  32  byte address of read
r_bmul  in  2  00 byte, 01 half, 10 word, 11 invalid
r_data  out  32  read result, zero-extended, registered
w_en  in  1  write request, sampled on rising clk
w_addr  in  32  byte address of write
w_data  in  32  write data, LSB-aligned (byte in [7:0], half in [15:0])
w_bmul  in  2  same encoding as r_bmul
err_clr  in  1  clears misalign_err
misalign_err  out  1  sticky: set on any misaligned or invalid-bmul access
leds  out  8  MMIO LED register

Behaviour:
Reset (async, rst=1):
- r_data=0, leds=0, misalign_err=0, cycle counter=0.
- RAM contents are not reset.
- A write sampled in the same edge as reset assertion is dropped.

Request validity:
- A request is accepted only on a rising clk with clk_enable=1 and en=1.
- Alignment is legal if: byte always; half needs addr[0]=0; word needs addr[1:0]=00.
- bmul=11 is always illegal.
- An illegal request sets misalign_err on that edge, performs no write, and returns r_data=0 for reads.

Addressing:
- addr[MMIO_BIT]=0: RAM word index = addr[ADDR_W+1:2]; higher bits ignored (aliasing, no error).
- addr[MMIO_BIT]=1: MMIO. Offset addr[3:2]: 0 = cycle counter (read-only, writes ignored); 1 = LED register (leds <= w_data[7:0] on any legal write, read returns {24'b0,leds}); 2,3 = read 0, writes ignored.
- Byte/half accesses to MMIO follow the same lane rules as RAM.

Read path (latency exactly 1):
- Edge N samples the request; r_data is valid after edge N and holds until the next accepted read or reset.
- Byte: r_data = {24'b0, word[8*addr[1:0] +: 8]}.
- Half: r_data = {16'b0, word[16*addr[1] +: 16]}.
- Word: r_data = word.
- No sign extension; the core performs it.

Write path:
- Byte lanes are little-endian.
- Byte writes only lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all four lanes.
- Unwritten lanes are preserved.

Simultaneous events:
- Read and write on the same edge to the same word: read returns the old (pre-write) data.
- Both requests illegal: misalign_err set once; no side effects.
- err_clr and a new error on the same edge: set wins.
- MMIO read of the counter returns its value before that edge's increment.

Cycle counter:
- 32-bit, +1 every clk edge when rst=0, independent of clk_enable.
- Wraps FFFF_FFFF -> 0000_0000 silently.

clk_enable=0:
- No request is accepted, r_data and leds hold, misalign_err holds.
- err_clr is still honoured.

Test Plan:
1. Word write 0xDEADBEEF @0x10, then word read @0x10 -> r_data=0xDEADBEEF one edge after read sampled; byte read @0x13 -> 0x000000DE; half read @0x12 -> 0x0000DEAD.
2. After (1): byte write 0x55 @0x11, then word read @0x10 -> 0xDEAD55EF; half write 0x1234 @0x12, then word read -> 0x123455EF.
3. Word read @0x12, half write @0x01, r_bmul=11 read @0x0 -> misalign_err=1 after first, r_data=0, RAM @0x0 unchanged; err_clr=1 -> misalign_err=0; err_clr with simultaneous illegal access -> remains 1.
4. Same-edge word write 0x11111111 and word read @0x20 (old 0xAAAAAAAA) -> r_data=0xAAAAAAAA; next read -> 0x11111111.
5. Write 0x000001A5 @0x8000_0004 -> leds=0xA5, read @0x8000_0004 -> 0x000000A5; two reads of @0x8000_0000 K edges apart differ by K; write to counter ignored.
6. Assert rst mid-sequence with w_en=1 @0x30 -> r_data=0, leds=0, err=0, counter=0 immediately (async); subsequent read @0x30 shows the pre-reset contents; with clk_enable=0 a write @0x30 has no effect.
